tft_init_sequencer: RTL and testbench
=====================================

// Module: tft_init_sequencer
// PURPOSE
//  Walks the TFT init-command ROM (addr -> {RS, 16-bit word}) and issues each word, in order, to the TFT SPI word transmitter.
//  Also performs the panel hardware reset first. Inserts the required power-on delays between ROM entries.
//  Asserts done once the final GRAM-write command is accepted; pixel streaming takes over after that.
// PARAMETERS
//  CYCLES_PER_MS  50000  clk cycles per millisecond (set small, e.g. 4, in simulation)
//  FIRST_ADDR     1      first ROM address sent (address 0 is a dummy entry, never sent)
//  LAST_ADDR      89     last ROM address sent (GRAM_DATA_REG command)
//  RST_LOW_MS     10     tft_rst_n low time
//  RST_WAIT_MS    50     wait after tft_rst_n rises before the first word
//  D1_IDX/D1_MS   10/40  delay after word D1_IDX is accepted
//  D2_IDX/D2_MS   20/10  delay after word D2_IDX is accepted
//  D3_IDX/D3_MS   22/50  delay after word D3_IDX is accepted
//  D4_IDX/D4_MS   86/50  delay after word D4_IDX is accepted
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   one-cycle pulse; begins the sequence when not busy
//  rom_addr   out  7   ROM address
//  rom_data   in   16  ROM word (combinational from rom_addr)
//  rom_rs     in   1   ROM RS bit (0 = index/command, 1 = parameter)
//  tx_valid   out  1   word offered to the SPI transmitter
//  tx_data    out  16  word to send (= rom_data)
//  tx_rs      out  1   RS for the word (= rom_rs)
//  tx_ready   in   1   transmitter accepts the word on valid&&ready
//  tft_rst_n  out  1   panel hardware reset, active low
//  busy       out  1   sequence in progress
//  done       out  1   sequence complete; held until the next start or rst
// BEHAVIOUR
//  Reset values: state=IDLE, rom_addr=0, tx_valid=0, tft_rst_n=1, busy=0, done=0, delay counter=0.
//  States:
//   IDLE:     wait for start. On start -> RST_LOW; load counter RST_LOW_MS*CYCLES_PER_MS-1.
//   RST_LOW:  tft_rst_n=0. When counter==0 -> RST_WAIT; load RST_WAIT_MS*CYCLES_PER_MS-1.
//   RST_WAIT: tft_rst_n=1. When counter==0 -> SEND; rom_addr=FIRST_ADDR.
//   SEND:     tx_valid=1. On valid&&ready:
//              if rom_addr==LAST_ADDR -> DONE;
//              elif rom_addr==Dk_IDX with Dk_MS>0 -> DELAY, load Dk_MS*CYCLES_PER_MS-1, rom_addr+1;
//              else stay in SEND with rom_addr+1.
//   DELAY:    tx_valid=0; decrement counter. When counter==0 -> SEND.
//   DONE:     done=1, busy=0, tx_valid=0, rom_addr holds LAST_ADDR. start -> RST_LOW, done cleared.
//  Counters: each timed state lasts exactly N*CYCLES_PER_MS cycles. Counter width is clog2 of the largest load.
//  Busy: busy=1 in RST_LOW, RST_WAIT, SEND and DELAY.
//  Handshake: tx_valid, tx_data and tx_rs are stable from assertion until accepted.
//   tx_valid never drops without acceptance (except on rst).
//   Back-to-back words are allowed: the new address is presented the cycle after acceptance.
//  Dataflow: tx_data/tx_rs are combinational pass-through of rom_data/rom_rs; tx_valid decodes from state.
//  Boundary conditions:
//   - start while busy is ignored.
//   - start and rst in the same cycle: rst wins.
//   - rst mid-sequence (any state): all outputs return to reset values next cycle; no partial resume.
//   - Dk_MS==0 produces no DELAY state, so there is no gap.
//   - If two Dk_IDX are equal, the first matching k is used.
//   - Exactly LAST_ADDR-FIRST_ADDR+1 words are transferred per sequence.
// TESTING (CYCLES_PER_MS=4, default delays, behavioural ROM model)
//  1. rst, then start pulse -> tft_rst_n low exactly 40 cycles, then high 200 cycles.
//     Then tx_valid=1, rom_addr=1, tx_rs=0, tx_data=16'h0010.
//  2. tx_ready tied 1 -> 89 transfers at addresses 1..89 in order.
//     Gaps of 160 cycles after 10, 40 after 20, 200 after 22 and 200 after 86.
//     done=1 the cycle after address 89 is accepted (tx_data=16'h0022, tx_rs=0).
//  3. Random tx_ready (~30% duty) -> tx_data/tx_rs stable while tx_valid && !tx_ready.
//     Scoreboard matches the ROM sequence with no loss or duplication.
//  4. rst asserted mid-DELAY after address 20 -> next cycle IDLE reset values.
//     A new start replays the full sequence from the tft_rst_n pulse.
//  5. start pulsed during SEND -> ignored. start in DONE -> done=0 and tft_rst_n=0 the next cycle.
//  6. D2_MS=0 override -> address 21 is offered the cycle after address 20 is accepted.

Source files
------------

// File: rtl/tft_init_sequencer.sv
// Sequences the TFT panel bring-up: hardware reset pulse, then every init-ROM word in order
// to the SPI word transmitter, with the power-on delays the panel needs between certain words.
module tft_init_sequencer #(
    parameter int CYCLES_PER_MS = 50000,
    parameter int FIRST_ADDR    = 1,
    parameter int LAST_ADDR     = 89,
    parameter int RST_LOW_MS    = 10,
    parameter int RST_WAIT_MS   = 50,
    parameter int D1_IDX        = 10,
    parameter int D1_MS         = 40,
    parameter int D2_IDX        = 20,
    parameter int D2_MS         = 10,
    parameter int D3_IDX        = 22,
    parameter int D3_MS         = 50,
    parameter int D4_IDX        = 86,
    parameter int D4_MS         = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [6:0]  rom_addr,
    input  logic [15:0] rom_data,
    input  logic        rom_rs,
    output logic        tx_valid,
    output logic [15:0] tx_data,
    output logic        tx_rs,
    input  logic        tx_ready,
    output logic        tft_rst_n,
    output logic        busy,
    output logic        done
);

    // state    | meaning
    // IDLE     | waiting for start
    // RST_LOW  | panel reset held low
    // RST_WAIT | panel reset released, waiting for the panel to wake
    // SEND     | offering the word at rom_addr to the transmitter
    // DELAY    | power-on pause after a specific word
    // DONE     | all words sent; pixel streaming owns the bus
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RST_LOW  = 3'd1;
    localparam logic [2:0] S_RST_WAIT = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_DELAY    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int LD_RL_I = RST_LOW_MS  * CYCLES_PER_MS - 1;
    localparam int LD_RW_I = RST_WAIT_MS * CYCLES_PER_MS - 1;
    localparam int LD_D1_I = D1_MS * CYCLES_PER_MS - 1;
    localparam int LD_D2_I = D2_MS * CYCLES_PER_MS - 1;
    localparam int LD_D3_I = D3_MS * CYCLES_PER_MS - 1;
    localparam int LD_D4_I = D4_MS * CYCLES_PER_MS - 1;

    localparam int MAX_LD = max2(max2(max2(LD_RL_I, LD_RW_I), max2(LD_D1_I, LD_D2_I)),
                                 max2(max2(LD_D3_I, LD_D4_I), 1));
    localparam int CNT_W  = $clog2(MAX_LD + 1);

    localparam logic [CNT_W-1:0] LD_RL = CNT_W'(LD_RL_I);
    localparam logic [CNT_W-1:0] LD_RW = CNT_W'(LD_RW_I);
    localparam logic [CNT_W-1:0] LD_D1 = CNT_W'(LD_D1_I);
    localparam logic [CNT_W-1:0] LD_D2 = CNT_W'(LD_D2_I);
    localparam logic [CNT_W-1:0] LD_D3 = CNT_W'(LD_D3_I);
    localparam logic [CNT_W-1:0] LD_D4 = CNT_W'(LD_D4_I);

    localparam logic [6:0] A_FIRST = 7'(FIRST_ADDR);
    localparam logic [6:0] A_LAST  = 7'(LAST_ADDR);

    logic [2:0]       state_q, state_d;
    logic [6:0]       addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_zero;
    logic             dly_hit;
    logic [CNT_W-1:0] dly_load;

    assign cnt_zero = (cnt_q == '0);

    // First matching index wins; a zero-length delay at that index means no pause.
    always_comb begin
        dly_hit  = 1'b0;
        dly_load = '0;
        if (addr_q == 7'(D1_IDX)) begin
            dly_hit  = (D1_MS > 0);
            dly_load = LD_D1;
        end else if (addr_q == 7'(D2_IDX)) begin
            dly_hit  = (D2_MS > 0);
            dly_load = LD_D2;
        end else if (addr_q == 7'(D3_IDX)) begin
            dly_hit  = (D3_MS > 0);
            dly_load = LD_D3;
        end else if (addr_q == 7'(D4_IDX)) begin
            dly_hit  = (D4_MS > 0);
            dly_load = LD_D4;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RST_LOW;
                    cnt_d   = LD_RL;
                    addr_d  = '0;
                end
            end
            S_RST_LOW: begin
                if (cnt_zero) begin
                    state_d = S_RST_WAIT;
                    cnt_d   = LD_RW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RST_WAIT: begin
                if (cnt_zero) begin
                    state_d = S_SEND;
                    addr_d  = A_FIRST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (addr_q == A_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d = addr_q + 7'd1;
                        if (dly_hit) begin
                            state_d = S_DELAY;
                            cnt_d   = dly_load;
                        end
                    end
                end
            end
            S_DELAY: begin
                if (cnt_zero) begin
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Word and RS come straight from the ROM, so they stay put while the address is held.
    assign rom_addr  = addr_q;
    assign tx_data   = rom_data;
    assign tx_rs     = rom_rs;
    assign tx_valid  = (state_q == S_SEND);
    assign tft_rst_n = (state_q != S_RST_LOW);
    assign busy      = (state_q == S_RST_LOW) || (state_q == S_RST_WAIT) ||
                       (state_q == S_SEND)    || (state_q == S_DELAY);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_tft_init_sequencer.sv
// Directed bench for tft_init_sequencer: scoreboard of ROM words, reset-pulse timing,
// inter-word gaps, handshake stability, start/rst corner cases and a zero-delay variant.
module tb_tft_init_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start2;
    logic [6:0]  rom_addr, rom_addr2;
    logic [15:0] rom_data, rom_data2, tx_data, tx_data2;
    logic        rom_rs, rom_rs2, tx_rs, tx_rs2;
    logic        tx_valid, tx_valid2, tx_ready, tx_ready2;
    logic        tft_rst_n, tft_rst_n2, busy, busy2, done, done2;

    assign tx_ready2 = 1'b1;

    function automatic logic [16:0] rom_fn(input logic [6:0] a);
        logic [15:0] d;
        logic        rs;
        d  = 16'h5A00 ^ {a, 9'h000} ^ {9'h000, a};
        rs = a[0] ^ a[3];
        if (a == 7'd1)  begin d = 16'h0010; rs = 1'b0; end
        if (a == 7'd89) begin d = 16'h0022; rs = 1'b0; end
        return {rs, d};
    endfunction

    always_comb {rom_rs, rom_data}   = rom_fn(rom_addr);
    always_comb {rom_rs2, rom_data2} = rom_fn(rom_addr2);

    tft_init_sequencer #(.CYCLES_PER_MS(4)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data), .rom_rs(rom_rs),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_rs(tx_rs), .tx_ready(tx_ready),
        .tft_rst_n(tft_rst_n), .busy(busy), .done(done)
    );

    tft_init_sequencer #(.CYCLES_PER_MS(4), .D2_MS(0)) u_d2 (
        .clk(clk), .rst(rst), .start(start2),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .rom_rs(rom_rs2),
        .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_rs(tx_rs2), .tx_ready(tx_ready2),
        .tft_rst_n(tft_rst_n2), .busy(busy2), .done(done2)
    );

    typedef struct packed {
        logic [6:0]  addr;
        logic        rs;
        logic [15:0] data;
    } word_t;

    word_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    ready_mode = 0;   // 0: ready low, 1: ready high, 2: ~30% random
    bit    prev_stall;
    word_t prev_w;
    bit    after_acc;
    int    idle_run;
    int    last_acc_addr;
    int    n_acc;
    int    low_run;
    bit    wait_pending;
    int    wait_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_gap(input int a);
        case (a)
            10:      return 160;
            20:      return 40;
            22:      return 200;
            86:      return 200;
            default: return 0;
        endcase
    endfunction

    task automatic clear_mon();
        prev_stall   = 1'b0;
        after_acc    = 1'b0;
        idle_run     = 0;
        last_acc_addr = 0;
        low_run      = 0;
        wait_pending = 1'b0;
        wait_run     = 0;
    endtask

    // One cycle: sample outputs at the falling edge, check, then drive tx_ready for the next rise.
    task automatic cyc_step();
        word_t w;
        @(negedge clk);
        if (rst) begin
            clear_mon();
            tx_ready = 1'b0;
            return;
        end
        if (!tft_rst_n) begin
            low_run++;
        end else if (low_run > 0) begin
            chk("rst_low_len", low_run, 40);
            low_run      = 0;
            wait_pending = 1'b1;
            wait_run     = 0;
        end
        if (wait_pending) begin
            if (tx_valid) begin
                chk("rst_wait_len", wait_run, 200);
                chk("first_addr", rom_addr, 1);
                chk("first_data", tx_data, 16'h0010);
                chk("first_rs", tx_rs, 0);
                wait_pending = 1'b0;
            end else begin
                wait_run++;
            end
        end
        if (prev_stall) begin
            chk("hold_valid", tx_valid, 1);
            chk("hold_word", {rom_addr, tx_rs, tx_data}, prev_w);
        end
        if (after_acc) begin
            if (last_acc_addr == 89) begin
                chk("done_after_last", done, 1);
                chk("valid_after_last", tx_valid, 0);
                chk("addr_after_last", rom_addr, 89);
                chk("busy_after_last", busy, 0);
                after_acc = 1'b0;
            end else if (tx_valid) begin
                chk($sformatf("gap_after_%0d", last_acc_addr), idle_run, exp_gap(last_acc_addr));
                after_acc = 1'b0;
            end else begin
                idle_run++;
            end
        end
        case (ready_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = ($urandom_range(0, 9) < 3);
        endcase
        prev_stall = 1'b0;
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                w = exp_q.pop_front();
                chk("sb_addr", rom_addr, w.addr);
                chk("sb_data", tx_data, w.data);
                chk("sb_rs", tx_rs, w.rs);
            end
            n_acc++;
            last_acc_addr = int'(rom_addr);
            after_acc     = 1'b1;
            idle_run      = 0;
        end else if (tx_valid) begin
            prev_stall = 1'b1;
            prev_w     = {rom_addr, tx_rs, tx_data};
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc_step();
        rst = 1'b0;
        clear_mon();
        exp_q.delete();
        chk("rst_addr", rom_addr, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_tft_rst_n", tft_rst_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
    endtask

    task automatic pulse_start();
        word_t w;
        for (int a = 1; a <= 89; a++) begin
            {w.rs, w.data} = rom_fn(7'(a));
            w.addr = 7'(a);
            exp_q.push_back(w);
        end
        n_acc = 0;
        start = 1'b1;
        cyc_step();
        start = 1'b0;
        chk("start_done_clr", done, 0);
        chk("start_tft_rst_n", tft_rst_n, 0);
        chk("start_busy", busy, 1);
    endtask

    task automatic run_to_done(input int budget);
        for (int i = 0; i < budget && !done; i++) cyc_step();
        chk("done_reached", done, 1);
        chk("word_count", n_acc, 89);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit seen20;
        bit hit;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; tx_ready = 1'b0;
        n_acc = 0;
        clear_mon();
        cyc_step();

        // reset values, then full sequence with tx_ready tied high
        do_reset();
        ready_mode = 1;
        pulse_start();
        run_to_done(2000);

        // random back-pressure; a start while sending must be ignored
        ready_mode = 2;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            cyc_step();
            hit = tx_valid && (n_acc >= 3);
        end
        chk("reach_send", hit, 1);
        start = 1'b1;
        cyc_step();
        start = 1'b0;
        chk("start_in_send_busy", busy, 1);
        chk("start_in_send_rst_n", tft_rst_n, 1);
        run_to_done(6000);

        // rst in the DELAY after address 20, then a clean replay
        ready_mode = 1;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            cyc_step();
            hit = (last_acc_addr == 20) && !tx_valid;
        end
        chk("reach_delay20", hit, 1);
        cyc_step();
        cyc_step();
        do_reset();
        pulse_start();
        run_to_done(2000);

        // zero-length delay after word 20: word 21 follows immediately
        start2 = 1'b1;
        cyc_step();
        start2 = 1'b0;
        chk("d2_start_rst_n", tft_rst_n2, 0);
        seen20 = 1'b0;
        hit    = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            cyc_step();
            if (seen20) begin
                chk("d2_valid_21", tx_valid2, 1);
                chk("d2_addr_21", rom_addr2, 21);
                hit = 1'b1;
            end else if (tx_valid2 && rom_addr2 == 7'd20) begin
                seen20 = 1'b1;
            end
        end
        chk("d2_reached_20", hit, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
